// File: rtl/alu_pkg.sv
// ----------------------------------------------------------------------------
// alu_pkg
//   Shared definitions for the ALU arbiter: the data width, the 4-bit ALU
//   opcode enumeration, and the combinational ALU evaluation function.
//
//   Contents:
//     XLEN          - integer data width (32)
//     alu_op_t      - opcode encoding (0..9 legal, 10..15 produce 0)
//     ALU_OP_LAST   - highest legal opcode
//     alu_exec()    - result of one ALU operation
//     alu_op_bad()  - 1 for opcodes above ALU_OP_LAST
// ----------------------------------------------------------------------------
package alu_pkg;

    localparam int XLEN = 32;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLL  = 4'd2,
        ALU_SLT  = 4'd3,
        ALU_SLTU = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_OR   = 4'd8,
        ALU_AND  = 4'd9
    } alu_op_t;

    localparam logic [3:0] ALU_OP_LAST = 4'd9;

    // Only B[4:0] is used as the shift amount; illegal opcodes fall into the
    // default arm and return zero.
    function automatic logic [XLEN-1:0] alu_exec(input logic [XLEN-1:0] a,
                                                 input logic [XLEN-1:0] b,
                                                 input logic [3:0]      op);
        logic [4:0]      shamt;
        logic [XLEN-1:0] res;
        shamt = b[4:0];
        res   = '0;
        case (op)
            ALU_ADD:  res = a + b;
            ALU_SUB:  res = a - b;
            ALU_SLL:  res = a << shamt;
            ALU_SLT:  res = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
            ALU_SLTU: res = {{(XLEN-1){1'b0}}, (a < b)};
            ALU_XOR:  res = a ^ b;
            ALU_SRL:  res = a >> shamt;
            ALU_SRA:  res = $unsigned($signed(a) >>> shamt);
            ALU_OR:   res = a | b;
            ALU_AND:  res = a & b;
            default:  res = '0;
        endcase
        return res;
    endfunction

    function automatic logic alu_op_bad(input logic [3:0] op);
        return op > ALU_OP_LAST;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// ----------------------------------------------------------------------------
// rr_pick
//   Purely combinational round-robin picker. Searches req starting at ptr,
//   then ptr+1, ... modulo NREQ, and reports the first requester found.
//
//   Ports:
//     req        in  [NREQ-1:0]  request vector
//     ptr        in  [ID_W-1:0]  highest-priority index this cycle (< NREQ)
//     gnt_onehot out [NREQ-1:0]  one-hot grant (all zero when no request)
//     gnt_idx    out [ID_W-1:0]  binary grant index (0 when no request)
//     any        out             at least one request present
// ----------------------------------------------------------------------------
module rr_pick #(
    parameter int NREQ = 2,
    parameter int ID_W = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [ID_W-1:0] ptr,
    output logic [NREQ-1:0] gnt_onehot,
    output logic [ID_W-1:0] gnt_idx,
    output logic            any
);

    logic [ID_W-1:0] w_idx;

    // Walk the search order backwards so the last hit written is the one
    // closest to ptr, i.e. the highest-priority requester.
    always_comb begin
        gnt_onehot = '0;
        gnt_idx    = '0;
        w_idx      = '0;
        any        = |req;
        for (int k = NREQ - 1; k >= 0; k--) begin
            w_idx = ID_W'((int'(ptr) + k) % NREQ);
            if (req[w_idx]) begin
                gnt_idx = w_idx;
            end
        end
        if (any) begin
            gnt_onehot[gnt_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// ----------------------------------------------------------------------------
// alu_arbiter
//   Shares one combinational 32-bit ALU between NREQ requesters. One
//   requester is accepted per cycle by round-robin; its result is captured in
//   a single output register tagged with the requester id and held until the
//   consumer takes it.
//
//   Optional feature: define ALU_ARB_ILLEGAL_CHK_EN to add the rsp_err port,
//   which flags results produced by opcodes 10..15.
//
//   Handshake: a transfer happens on a channel in a cycle where its valid and
//   ready are both high at the rising clock edge. Producers hold valid and
//   payload stable until ready; valid never depends combinationally on ready.
//   rsp_* stay stable while rsp_valid && !rsp_ready.
//
//   Ports:
//     clk, rst                    clock, synchronous active-high reset
//     req_valid/req_ready [NREQ]  per-requester operand channel
//     req_a, req_b [NREQ*32]      operands, slice i = [32*i +: 32]
//     req_op [NREQ*4]             opcode, slice i = [4*i +: 4]
//     rsp_valid/rsp_ready         result channel
//     rsp_data [32], rsp_id       result and producing requester
//     rsp_err                     illegal-op flag (ALU_ARB_ILLEGAL_CHK_EN)
// ----------------------------------------------------------------------------
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int ID_W = $clog2(NREQ)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*32-1:0] req_a,
    input  logic [NREQ*32-1:0] req_b,
    input  logic [NREQ*4-1:0] req_op,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [XLEN-1:0]   rsp_data,
    output logic [ID_W-1:0]   rsp_id
`ifdef ALU_ARB_ILLEGAL_CHK_EN
    ,
    output logic              rsp_err
`endif
);

    logic [ID_W-1:0] r_ptr;
    logic            r_rsp_valid;
    logic [XLEN-1:0] r_rsp_data;
    logic [ID_W-1:0] r_rsp_id;

    logic            w_can_accept;
    logic            w_accept;
    logic [NREQ-1:0] w_gnt_onehot;
    logic [ID_W-1:0] w_gnt_idx;
    logic            w_any;
    logic [ID_W-1:0] w_ptr_next;
    logic [XLEN-1:0] w_a;
    logic [XLEN-1:0] w_b;
    logic [3:0]      w_op;
    logic [XLEN-1:0] w_result;

    rr_pick #(
        .NREQ (NREQ),
        .ID_W (ID_W)
    ) u_pick (
        .req        (req_valid),
        .ptr        (r_ptr),
        .gnt_onehot (w_gnt_onehot),
        .gnt_idx    (w_gnt_idx),
        .any        (w_any)
    );

    // A new result may enter when the register is empty or being drained
    // this same cycle, which gives back-to-back throughput with no bubble.
    assign w_can_accept = !r_rsp_valid || rsp_ready;
    assign w_accept     = w_any && w_can_accept && !rst;
    assign req_ready    = rst ? '0 : (w_gnt_onehot & {NREQ{w_can_accept}});

    assign w_ptr_next   = (w_gnt_idx == ID_W'(NREQ - 1)) ? '0 : w_gnt_idx + 1'b1;

    // Operand mux keyed by the one-hot grant, so the ready path never sees
    // operand or opcode bits.
    always_comb begin
        w_a  = '0;
        w_b  = '0;
        w_op = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_gnt_onehot[i]) begin
                w_a  = req_a[32*i +: 32];
                w_b  = req_b[32*i +: 32];
                w_op = req_op[4*i +: 4];
            end
        end
    end

    assign w_result = alu_exec(w_a, w_b, w_op);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr       <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
            r_rsp_id    <= '0;
        end else begin
            if (w_accept) begin
                r_ptr       <= w_ptr_next;
                r_rsp_valid <= 1'b1;
                r_rsp_data  <= w_result;
                r_rsp_id    <= w_gnt_idx;
            end else if (rsp_ready) begin
                // Drain only: data and id keep their last values.
                r_rsp_valid <= 1'b0;
            end
        end
    end

    assign rsp_valid = r_rsp_valid;
    assign rsp_data  = r_rsp_data;
    assign rsp_id    = r_rsp_id;

`ifdef ALU_ARB_ILLEGAL_CHK_EN
    logic r_rsp_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rsp_err <= 1'b0;
        end else if (w_accept) begin
            r_rsp_err <= alu_op_bad(w_op);
        end
    end

    assign rsp_err = r_rsp_err;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// ----------------------------------------------------------------------------
// tb_alu_arbiter
//   Self-checking bench for alu_arbiter with NREQ=3. Stimulus is issued one
//   clock at a time; accepted operations push their expected response into a
//   queue and a separate monitor pops and compares as results are consumed.
// ----------------------------------------------------------------------------
module tb_alu_arbiter;

    localparam int NREQ = 3;
    localparam int ID_W = $clog2(NREQ);
    localparam int EW   = 1 + ID_W + 32;   // {err, id, data}

    logic                clk = 1'b0;
    logic                rst;
    logic [NREQ-1:0]     req_valid;
    logic [NREQ-1:0]     req_ready;
    logic [NREQ*32-1:0]  req_a;
    logic [NREQ*32-1:0]  req_b;
    logic [NREQ*4-1:0]   req_op;
    logic                rsp_valid;
    logic                rsp_ready;
    logic [31:0]         rsp_data;
    logic [ID_W-1:0]     rsp_id;
`ifdef ALU_ARB_ILLEGAL_CHK_EN
    logic                rsp_err;
`endif

    alu_arbiter #(.NREQ(NREQ)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_op    (req_op),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_id    (rsp_id)
`ifdef ALU_ARB_ILLEGAL_CHK_EN
        ,
        .rsp_err   (rsp_err)
`endif
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- bench state ----------------
    int           n_chk  = 0;
    int           n_fail = 0;
    logic [EW-1:0] exp_q[$];
    int           obs_grants[$];

    logic [31:0]  s_a   [NREQ];
    logic [31:0]  s_b   [NREQ];
    logic [3:0]   s_op  [NREQ];
    logic [31:0]  s_exp [NREQ];
    bit           s_pend[NREQ];
    int           wait_cnt[NREQ];
    int           last_winner;
    bit           rst_v;
    bit           rdy_v;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference ALU ----------------
    function automatic logic [31:0] model_alu(input logic [31:0] a, input logic [31:0] b,
                                              input logic [3:0] op);
        int sh;
        int sa;
        int sb;
        sh = int'(b % 32);
        sa = a;
        sb = b;
        case (int'(op))
            0:       return a + b;
            1:       return a - b;
            2:       return a << sh;
            3:       return (sa < sb) ? 32'd1 : 32'd0;
            4:       return (a < b) ? 32'd1 : 32'd0;
            5:       return a ^ b;
            6:       return a >> sh;
            7:       return a[31] ? ((a >> sh) | ~(32'hFFFF_FFFF >> sh)) : (a >> sh);
            8:       return a | b;
            9:       return a & b;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] rnd_word();
        case ($urandom_range(0, 5))
            0:       return 32'h0000_0000;
            1:       return 32'h0000_0001;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    // ---------------- driver tasks ----------------
    task automatic load_exp(input int i, input logic [31:0] a, input logic [31:0] b,
                            input logic [3:0] op, input logic [31:0] expv);
        s_a[i]    = a;
        s_b[i]    = b;
        s_op[i]   = op;
        s_exp[i]  = expv;
        s_pend[i] = 1'b1;
    endtask

    task automatic load(input int i, input logic [31:0] a, input logic [31:0] b,
                        input logic [3:0] op);
        load_exp(i, a, b, op, model_alu(a, b, op));
    endtask

    // One clock: drive at the falling edge, then check the grant the model
    // expects for the coming rising edge and book-keep any accept.
    task automatic step();
        logic [NREQ-1:0] exp_rdy;
        logic            err_bit;
        int              g;
        bit              can_acc;
        @(negedge clk);
        rst       = rst_v;
        rsp_ready = rdy_v;
        for (int i = 0; i < NREQ; i++) begin
            req_valid[i]       = s_pend[i];
            req_a[32*i +: 32]  = s_a[i];
            req_b[32*i +: 32]  = s_b[i];
            req_op[4*i +: 4]   = s_op[i];
        end
        #3;
        exp_rdy = '0;
        g       = -1;
        can_acc = (exp_q.size() == 0) || rdy_v;
        if (!rst_v) begin
            for (int k = 0; k < NREQ; k++) begin
                int idx;
                idx = (last_winner + 1 + k) % NREQ;
                if (s_pend[idx] && g < 0) g = idx;
            end
        end
        if (g >= 0 && can_acc) exp_rdy[g] = 1'b1;
        check("req_ready", 64'(req_ready), 64'(exp_rdy));

        // Starvation bound measured on the accepts the DUT actually makes.
        for (int j = 0; j < NREQ; j++) begin
            if (req_valid[j] && req_ready[j]) begin
                obs_grants.push_back(j);
                for (int i = 0; i < NREQ; i++) begin
                    if (i != j && s_pend[i]) begin
                        wait_cnt[i]++;
                        check("wait_bound", 64'(wait_cnt[i] <= NREQ - 1), 64'd1);
                    end
                end
                wait_cnt[j] = 0;
            end
        end

        if (rst_v) begin
            exp_q.delete();
            last_winner = -1;
            for (int i = 0; i < NREQ; i++) wait_cnt[i] = 0;
        end else if (exp_rdy != '0) begin
            err_bit = (s_op[g] > 4'd9);
            exp_q.push_back({err_bit, ID_W'(g), s_exp[g]});
            s_pend[g]   = 1'b0;
            last_winner = g;
        end
    endtask

    task automatic issue_wait(input int i, input logic [31:0] a, input logic [31:0] b,
                              input logic [3:0] op, input logic [31:0] expv);
        load_exp(i, a, b, op, expv);
        for (int t = 0; t < 10 && s_pend[i]; t++) step();
        check("issue_timeout", 64'(s_pend[i]), 64'd0);
    endtask

    task automatic drain();
        rdy_v = 1'b1;
        for (int t = 0; t < 20; t++) begin
            bit busy;
            busy = (exp_q.size() != 0);
            for (int i = 0; i < NREQ; i++) busy |= s_pend[i];
            if (busy) step();
        end
        step();
        check("drain_empty", 64'(exp_q.size()), 64'd0);
    endtask

    // ---------------- monitor / scoreboard ----------------
    initial begin
        logic [EW-1:0]   e;
        logic [31:0]     prev_d;
        logic [ID_W-1:0] prev_id;
        bit              prev_v;
        bit              prev_r;
        bit              have_prev;
        have_prev = 1'b0;
        prev_v    = 1'b0;
        prev_r    = 1'b0;
        prev_d    = '0;
        prev_id   = '0;
        forever begin
            @(negedge clk);
            #2;
            if (rst !== 1'b0) begin
                have_prev = 1'b0;
            end else begin
                check("rsp_valid", 64'(rsp_valid), 64'(exp_q.size() != 0));
                if (have_prev && prev_v && !prev_r) begin
                    check("hold_data", 64'(rsp_data), 64'(prev_d));
                    check("hold_id", 64'(rsp_id), 64'(prev_id));
                end
                if (rsp_valid && rsp_ready && exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("rsp_data", 64'(rsp_data), 64'(e[31:0]));
                    check("rsp_id", 64'(rsp_id), 64'(e[32 +: ID_W]));
`ifdef ALU_ARB_ILLEGAL_CHK_EN
                    check("rsp_err", 64'(rsp_err), 64'(e[EW-1]));
`endif
                end
                prev_v    = rsp_valid;
                prev_r    = rsp_ready;
                prev_d    = rsp_data;
                prev_id   = rsp_id;
                have_prev = 1'b1;
            end
        end
    end

    // ---------------- main sequence ----------------
    initial begin
        int n_before;
        rst         = 1'b1;
        rsp_ready   = 1'b0;
        req_valid   = '0;
        req_a       = '0;
        req_b       = '0;
        req_op      = '0;
        last_winner = -1;
        rst_v       = 1'b1;
        rdy_v       = 1'b1;
        for (int i = 0; i < NREQ; i++) begin
            s_a[i] = '0; s_b[i] = '0; s_op[i] = '0; s_exp[i] = '0;
            s_pend[i] = 1'b0; wait_cnt[i] = 0;
        end

        // Reset and reset values.
        repeat (2) step();
        rst_v = 1'b0;
        step();
        check("reset_valid", 64'(rsp_valid), 64'd0);
        check("reset_data", 64'(rsp_data), 64'd0);
        check("reset_id", 64'(rsp_id), 64'd0);
`ifdef ALU_ARB_ILLEGAL_CHK_EN
        check("reset_err", 64'(rsp_err), 64'd0);
`endif

        // Single request: 5 - 3 on requester 0.
        load_exp(0, 32'd5, 32'd3, 4'd1, 32'd2);
        step();
        step();

        // Fairness from reset with requesters 0 and 1 always valid.
        rst_v = 1'b1;
        step();
        rst_v = 1'b0;
        obs_grants.delete();
        for (int c = 0; c < 4; c++) begin
            for (int i = 0; i < 2; i++)
                if (!s_pend[i]) load(i, rnd_word(), rnd_word(), 4'($urandom_range(0, 9)));
            step();
        end
        check("fair_count", 64'(obs_grants.size()), 64'd4);
        for (int c = 0; c < 4 && c < obs_grants.size(); c++)
            check("fair_order", 64'(obs_grants[c]), 64'(c % 2));

        // Backpressure: result held three cycles, then drain + accept together.
        rdy_v = 1'b0;
        for (int i = 0; i < 2; i++)
            if (!s_pend[i]) load(i, rnd_word(), rnd_word(), 4'd0);
        repeat (3) step();
        n_before = obs_grants.size();
        rdy_v = 1'b1;
        step();
        check("bp_accept", 64'(obs_grants.size() - n_before), 64'd1);
        drain();

        // Arithmetic edges.
        issue_wait(2, 32'h8000_0000, 32'd33, 4'd7, 32'hC000_0000);
        issue_wait(1, 32'hFFFF_FFFF, 32'd0, 4'd3, 32'd1);
        issue_wait(0, 32'hFFFF_FFFF, 32'd0, 4'd4, 32'd0);
        issue_wait(2, 32'hFFFF_FFFF, 32'd1, 4'd0, 32'd0);
        issue_wait(1, 32'h0000_0001, 32'd31, 4'd2, 32'h8000_0000);
        drain();

        // Reset while a result is pending and ptr=1.
        issue_wait(0, 32'd10, 32'd20, 4'd0, 32'd30);
        rdy_v = 1'b0;
        step();
        rst_v = 1'b1;
        load(0, 32'd1, 32'd2, 4'd8);
        load(1, 32'd3, 32'd4, 4'd9);
        step();
        rst_v = 1'b0;
        obs_grants.delete();
        step();
        check("post_reset_grant", 64'(obs_grants.size() > 0 ? obs_grants[0] : -1), 64'd0);
        drain();

        // Illegal opcode.
        issue_wait(1, 32'd7, 32'd7, 4'd12, 32'd0);
        drain();

        // Randomized traffic with occasional resets.
        for (int c = 0; c < 400; c++) begin
            rdy_v = ($urandom_range(0, 3) != 0);
            rst_v = ($urandom_range(0, 99) == 0);
            for (int i = 0; i < NREQ; i++)
                if (!s_pend[i] && $urandom_range(0, 1) == 1)
                    load(i, rnd_word(), rnd_word(), 4'($urandom_range(0, 15)));
            step();
        end
        rst_v = 1'b0;
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares one combinational 32-bit integer ALU between `NREQ` requesters, such as the issue pipeline and an address-generation unit. Each requester has a valid/ready operand channel, and the block picks one requester per cycle with round-robin arbitration. It computes the result and holds it in a single output register, tagged with the requester id, until the consumer accepts it.

## Interface
Parameters:
- `NREQ`, default 2: number of requesters, 2..8.
- `ID_W`, default `$clog2(NREQ)`: width of the requester id.

Ports:
- `clk`, in, 1: the single clock.
- `rst`, in, 1: reset, synchronous and active-high.
- `req_valid`, in, NREQ: per-requester operation valid.
- `req_ready`, out, NREQ: per-requester accept. At most one bit is high in any cycle.
- `req_a`, in, NREQ*32: operand A per requester. Slice i is `[32*i +: 32]`.
- `req_b`, in, NREQ*32: operand B per requester.
- `req_op`, in, NREQ*4: ALU op code per requester.
- `rsp_valid`, out, 1: the result register holds a result.
- `rsp_ready`, in, 1: the consumer accepts the result.
- `rsp_data`, out, 32: the result.
- `rsp_id`, out, ID_W: index of the requester that produced the result.

## Operation
- Op encoding:
  - 0 ADD, 1 SUB, 2 SLL, 3 SLT (signed), 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND.
  - Ops 10..15 produce a result of 0.
  - Shift amount is `B[4:0]`. All arithmetic wraps modulo 2^32.
  - SLT and SLTU return 0 or 1, zero-extended.
- Accept condition: `can_accept = !rsp_valid || rsp_ready`.
- Arbitration:
  - Round-robin pointer `ptr`, width ID_W.
  - The grant goes to the first `i` with `req_valid[i]=1`, searching `ptr`, `ptr+1`, ... modulo NREQ.
  - `req_ready[grant]=can_accept`. All other ready bits are 0.
- On accept, where `req_valid[g] && req_ready[g]`:
  - Load `rsp_data` with the ALU result, `rsp_id` with g, and set `rsp_valid` to 1.
  - Set `ptr` to (g+1) mod NREQ.
- With no accept, `ptr` holds.
- Drain: `rsp_valid && rsp_ready` with no new accept clears `rsp_valid`. `rsp_data` and `rsp_id` hold their last values.
- Drain and accept in the same cycle: the register reloads, `rsp_valid` stays 1, and there is no bubble.
- Handshake rules:
  - A requester must hold valid, operands and op stable until ready.
  - `req_valid` must not depend combinationally on `req_ready`.
  - `rsp_valid`, `rsp_data` and `rsp_id` are stable while `rsp_valid && !rsp_ready`.
- No requester waits more than NREQ-1 accepts while it keeps valid asserted.

## Timing
- Reset values: `rsp_valid`=0, `rsp_data`=0, `rsp_id`=0, `ptr`=0.
- `req_ready` is 0 in every cycle where `rst`=1.
- Latency: 1 cycle. An accept at edge N gives `rsp_valid`=1 after edge N.
- Throughput: 1 operation per cycle while `rsp_ready`=1.
- `req_ready` is combinational from `req_valid`, `ptr`, `rsp_valid` and `rsp_ready`. It is not combinational from operands or op.
- Reset mid-operation: a pending result is discarded and nothing is accepted in the reset cycle. The first cycle after reset grants requester 0 first.

## Configuration
- Macro `ALU_ARB_ILLEGAL_CHK_EN`.
- Defined:
  - Adds output port `rsp_err`, out, 1, reset value 0.
  - `rsp_err` loads on accept, is 1 for ops 10..15 and 0 otherwise, and follows the same hold rules as `rsp_data`.
  - For illegal ops `rsp_data` is still 0.
- Undefined: no `rsp_err` port. Illegal ops silently return 0.

## Structure
- Package `alu_pkg`:
  - `alu_op_t` enum (4-bit) with the encoding above.
  - Constant `ALU_OP_LAST = 4'd9`.
  - Data width constant `XLEN = 32`.
- Sub-module `rr_pick`: a purely combinational round-robin picker.
  - Inputs: `req[NREQ]`, `ptr`.
  - Outputs: `gnt_onehot`, `gnt_idx`, `any`.
- The top level holds `ptr`, the output register and the ALU case logic.

## Test plan
1. Single request: req0 sends A=5, B=3, op=1 with `rsp_ready`=1.
   - `req_ready[0]`=1 in the same cycle.
   - Next cycle: `rsp_valid`=1, `rsp_id`=0, `rsp_data`=2.
2. Fairness: after reset, req0 and req1 are held valid with `rsp_ready`=1.
   - Accepts alternate 0,1,0,1, one per cycle, with no gaps.
3. Backpressure: with `rsp_valid`=1, hold `rsp_ready`=0 for 3 cycles.
   - `req_ready` is 0 and `rsp_data`/`rsp_id` are stable throughout.
   - Raising `rsp_ready` drains and accepts the next request in the same cycle.
4. Arithmetic edges:
   - SRA A=0x80000000, B=33 gives 0xC0000000.
   - SLT A=0xFFFFFFFF, B=0 gives 1; SLTU with the same operands gives 0.
   - ADD 0xFFFFFFFF+1 gives 0.
5. Reset mid-operation: assert `rst` for one cycle while `rsp_valid`=1 and ptr=1.
   - After reset: `rsp_valid`=0.
   - With req0 and req1 both valid, req0 is granted first.
6. Illegal op: op=12 with A=7, B=7.
   - With `ALU_ARB_ILLEGAL_CHK_EN`: `rsp_data`=0, `rsp_err`=1.
   - Without it: `rsp_data`=0.
